// File: rtl/pwm_ctrl_pkg.sv
// Shared types and helpers for the PWM soft-start/soft-stop controller.
package pwm_ctrl_pkg;

    localparam int DUTY_W           = 4;
    localparam int DEFAULT_DUTY_MAX = 10;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RAMP     = 2'd1,
        HOLD     = 2'd2,
        STOPPING = 2'd3
    } state_t;

    function automatic logic [DUTY_W-1:0] clamp_duty(
        input logic [DUTY_W-1:0] req,
        input logic [DUTY_W-1:0] duty_max
    );
        return (req > duty_max) ? duty_max : req;
    endfunction

endpackage

// File: rtl/pwm_period_timer.sv
// Free-running PWM period counter; the same instance pattern drives the PWM block.
module pwm_period_timer #(
    parameter int T  = 10,
    parameter int PW = $clog2(T)
) (
    input  logic          clk,
    input  logic          rst,
    output logic [PW-1:0] pcnt,
    output logic          period_tick
);

    localparam logic [PW-1:0] LAST = PW'(T - 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcnt <= '0;
        end else if (pcnt == LAST) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PW'(1);
        end
    end

    assign period_tick = (pcnt == LAST);

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Soft-start/soft-stop sequencer for the PWM duty input; duty only moves on period boundaries.
module pwm_ramp_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int T            = 10,
    parameter int DUTY_MAX     = DEFAULT_DUTY_MAX,
    parameter int STEP_PERIODS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [DUTY_W-1:0] target,
    output logic [DUTY_W-1:0] duty_cycle,
    output logic              period_tick,
    output logic              ramping,
    output logic              at_target,
    output logic              done
);

    localparam int PW = $clog2(T);
    localparam int SW = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
    localparam logic [DUTY_W-1:0] DMAX      = DUTY_W'(DUTY_MAX);
    localparam logic [SW-1:0]     SCNT_LAST = SW'(STEP_PERIODS - 1);

    state_t            state_reg;
    logic [DUTY_W-1:0] duty_reg;
    logic [DUTY_W-1:0] tgt_reg;
    logic [SW-1:0]     scnt_reg;
    logic              done_reg;
    logic [PW-1:0]     pcnt;
    logic              unused_pcnt;
    logic [DUTY_W-1:0] tgt_c;
    logic [DUTY_W-1:0] duty_step;
    logic              step_evt;

    pwm_period_timer #(.T(T), .PW(PW)) u_timer (
        .clk         (clk),
        .rst         (rst),
        .pcnt        (pcnt),
        .period_tick (period_tick)
    );

    assign unused_pcnt = ^pcnt;
    assign tgt_c       = clamp_duty(target, DMAX);
    assign step_evt    = period_tick && (scnt_reg == SCNT_LAST);

    always_comb begin
        duty_step = duty_reg;
        if (tgt_reg > duty_reg) begin
            duty_step = duty_reg + DUTY_W'(1);
        end else if (tgt_reg < duty_reg) begin
            duty_step = duty_reg - DUTY_W'(1);
        end
    end

    // Transition branches below override the free-running scnt update to clear it on entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            duty_reg  <= '0;
            tgt_reg   <= '0;
            scnt_reg  <= '0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (period_tick) begin
                scnt_reg <= step_evt ? '0 : scnt_reg + SW'(1);
            end
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        tgt_reg   <= tgt_c;
                        scnt_reg  <= '0;
                        state_reg <= (tgt_c == '0) ? HOLD : RAMP;
                    end
                end
                RAMP, HOLD: begin
                    if (stop) begin
                        scnt_reg <= '0;
                        if (duty_reg == '0) begin
                            state_reg <= IDLE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= STOPPING;
                        end
                    end else if (start) begin
                        tgt_reg <= tgt_c;
                        if (tgt_c == duty_reg) begin
                            if (state_reg == RAMP) begin
                                scnt_reg <= '0;
                            end
                            state_reg <= HOLD;
                        end else begin
                            scnt_reg  <= '0;
                            state_reg <= RAMP;
                        end
                    end else if (state_reg == RAMP && step_evt) begin
                        duty_reg <= duty_step;
                        if (duty_step == tgt_reg) begin
                            state_reg <= HOLD;
                        end
                    end
                end
                STOPPING: begin
                    if (step_evt && duty_reg != '0) begin
                        duty_reg <= duty_reg - DUTY_W'(1);
                        if (duty_reg == DUTY_W'(1)) begin
                            scnt_reg  <= '0;
                            state_reg <= IDLE;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign duty_cycle = duty_reg;
    assign ramping    = (state_reg == RAMP) || (state_reg == STOPPING);
    assign at_target  = (state_reg == HOLD);
    assign done       = done_reg;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Scoreboard bench for pwm_ramp_ctrl with T=10, STEP_PERIODS=2, DUTY_MAX=10.
module tb_pwm_ramp_ctrl;

    typedef struct {
        bit       is_done;
        bit [3:0] duty;
        bit       ramp;
        bit       at_t;
        int       gap;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [3:0] target = 4'd0;
    logic [3:0] duty_cycle;
    logic       period_tick, ramping, at_target, done;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_chg = 0;
    exp_t exp_q[$];

    pwm_ramp_ctrl #(.T(10), .DUTY_MAX(10), .STEP_PERIODS(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .target      (target),
        .duty_cycle  (duty_cycle),
        .period_tick (period_tick),
        .ramping     (ramping),
        .at_target   (at_target),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic push_duty(input int d, input bit r, input bit a, input int gap);
        exp_t e;
        e.is_done = 1'b0; e.duty = 4'(d); e.ramp = r; e.at_t = a; e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic push_done();
        exp_t e;
        e.is_done = 1'b1; e.duty = 4'd0; e.ramp = 1'b0; e.at_t = 1'b0; e.gap = 0;
        exp_q.push_back(e);
    endtask

    // Monitor: every duty change or done pulse is a DUT transaction matched against the queue.
    initial begin
        logic [3:0] prev_duty;
        logic       prev_tick;
        exp_t       e;
        prev_duty = 4'd0;
        prev_tick = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                prev_duty = 4'd0;
                prev_tick = 1'b0;
            end else begin
                if (duty_cycle !== prev_duty) begin
                    $display("[%0d] duty %0d -> %0d ramping=%0b at_target=%0b",
                             cyc, prev_duty, duty_cycle, ramping, at_target);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_duty_change", int'(duty_cycle), int'(prev_duty));
                    end else begin
                        e = exp_q.pop_front();
                        chk("event_is_duty", 0, int'(e.is_done));
                        chk("duty_value", int'(duty_cycle), int'(e.duty));
                        chk("duty_ramping", int'(ramping), int'(e.ramp));
                        chk("duty_at_target", int'(at_target), int'(e.at_t));
                        chk("duty_on_period_boundary", int'(prev_tick), 1);
                        if (e.gap != 0) chk("step_spacing", cyc - last_chg, e.gap);
                    end
                    last_chg  = cyc;
                    prev_duty = duty_cycle;
                end
                if (done) begin
                    $display("[%0d] done pulse duty=%0d", cyc, duty_cycle);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", int'(done), 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("event_is_done", 1, int'(e.is_done));
                        chk("done_duty", int'(duty_cycle), 0);
                        chk("done_ramping", int'(ramping), 0);
                        chk("done_at_target", int'(at_target), 0);
                    end
                end
                prev_tick = period_tick;
            end
        end
    end

    task automatic pulse(input bit s, input bit p, input int tg);
        @(negedge clk); #1;
        start = s; stop = p; target = 4'(tg);
        @(negedge clk); #1;
        start = 1'b0; stop = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); #1;
        end
    endtask

    task automatic wait_drain(input string name, input int limit);
        for (int i = 0; i < limit && exp_q.size() > 0; i++) begin
            @(negedge clk); #1;
        end
        checks++;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL %s: timeout with %0d events outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic measure_first_tick(input string name);
        int n;
        n = 0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            if (period_tick) begin
                n = i;
                break;
            end
        end
        chk(name, n, 9);
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_duty"}, int'(duty_cycle), 0);
        chk({name, "_tick"}, int'(period_tick), 0);
        chk({name, "_ramping"}, int'(ramping), 0);
        chk({name, "_at_target"}, int'(at_target), 0);
        chk({name, "_done"}, int'(done), 0);
    endtask

    initial begin
        // Reset state, before and after clocks run under reset
        #1;
        check_all_zero("reset_initial");
        idle_cycles(3);
        check_all_zero("reset_held");
        rst = 1'b1;
        measure_first_tick("first_tick_after_release");

        // Ramp 0 -> 3
        push_duty(1, 1, 0, 0);
        push_duty(2, 1, 0, 20);
        push_duty(3, 0, 1, 20);
        pulse(1'b1, 1'b0, 3);
        chk("start_ramping", int'(ramping), 1);
        chk("start_at_target", int'(at_target), 0);
        wait_drain("ramp_to_3", 100);

        // Stop from HOLD at 3
        push_duty(2, 1, 0, 0);
        push_duty(1, 1, 0, 20);
        push_duty(0, 0, 0, 20);
        push_done();
        pulse(1'b0, 1'b1, 0);
        wait_drain("stop_from_3", 100);
        idle_cycles(2);
        chk("idle_after_stop_ramping", int'(ramping), 0);

        // Clamp 15 -> 10, then retarget down to 6 without done
        for (int d = 1; d <= 10; d++) push_duty(d, (d != 10), (d == 10), (d == 1) ? 0 : 20);
        pulse(1'b1, 1'b0, 15);
        wait_drain("clamp_ramp_to_10", 300);
        idle_cycles(5);
        for (int d = 9; d >= 6; d--) push_duty(d, (d != 6), (d == 6), (d == 9) ? 0 : 20);
        pulse(1'b1, 1'b0, 6);
        wait_drain("retarget_to_6", 150);
        idle_cycles(30);
        chk("hold_at_6_at_target", int'(at_target), 1);
        for (int d = 5; d >= 0; d--) push_duty(d, (d != 0), 0, (d == 5) ? 0 : 20);
        push_done();
        pulse(1'b0, 1'b1, 0);
        wait_drain("stop_from_6", 200);

        // Start+stop together in RAMP at duty 4; start ignored while stopping
        for (int d = 1; d <= 4; d++) push_duty(d, 1, 0, (d == 1) ? 0 : 20);
        pulse(1'b1, 1'b0, 8);
        wait_drain("ramp_to_4", 150);
        for (int d = 3; d >= 0; d--) push_duty(d, (d != 0), 0, (d == 3) ? 0 : 20);
        push_done();
        pulse(1'b1, 1'b1, 9);
        chk("start_stop_ramping", int'(ramping), 1);
        idle_cycles(25);
        pulse(1'b1, 1'b0, 9);
        chk("start_in_stopping_ramping", int'(ramping), 1);
        chk("start_in_stopping_at_target", int'(at_target), 0);
        wait_drain("stop_from_4", 150);

        // Target 0 from IDLE: straight to HOLD, then stop gives done only
        pulse(1'b1, 1'b0, 0);
        chk("zero_target_at_target", int'(at_target), 1);
        chk("zero_target_ramping", int'(ramping), 0);
        idle_cycles(15);
        chk("zero_target_duty", int'(duty_cycle), 0);
        push_done();
        pulse(1'b0, 1'b1, 0);
        chk("zero_stop_at_target", int'(at_target), 0);
        wait_drain("zero_stop_done", 5);

        // Asynchronous reset mid-ramp at duty 5
        for (int d = 1; d <= 5; d++) push_duty(d, 1, 0, (d == 1) ? 0 : 20);
        pulse(1'b1, 1'b0, 9);
        wait_drain("ramp_to_5", 150);
        idle_cycles(3);
        rst = 1'b0;
        #1;
        check_all_zero("async_reset");
        idle_cycles(4);
        check_all_zero("reset_mid_ramp_held");
        rst = 1'b1;
        measure_first_tick("first_tick_after_mid_reset");
        idle_cycles(40);
        chk("post_reset_duty", int'(duty_cycle), 0);
        chk("post_reset_ramping", int'(ramping), 0);
        chk("post_reset_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time exceeded, required completion");
        $fatal(1, "timeout");
    end

endmodule
